// File: rtl/btb_assoc_if.sv
// -----------------------------------------------------------------------------
// btb_assoc_if -- fetch/decode bundle for the set-associative branch target
// buffer (btb_assoc).
//
// Signals
//   STALL               pipeline stall; high freezes all BTB state
//   Instr_PC_IN_IF      PC being fetched (lookup port)
//   Instr_PC_IN_ID      PC of the instruction in decode (update port)
//   is_Branch_IN_ID     decode instruction is a conditional branch
//   is_Taken_IN_ID      resolved direction of the decode branch
//   Alt_PC_IN_ID        resolved target of the decode branch
//   FLUSH               registered; one-cycle pulse on misprediction
//   take_Branch_OUT_IF  registered; fetch redirect valid
//   take_Alt_PC_OUT_IF  registered; next fetch PC
//   stat_hits_OUT       (BTB_STATS_EN only) saturating IF hit count
//   stat_mispred_OUT    (BTB_STATS_EN only) saturating mispredict count
//
// Modports: master = pipeline side, slave = BTB side.
// Optional macro: BTB_STATS_EN adds the statistics outputs.
// -----------------------------------------------------------------------------
interface btb_assoc_if;
  logic        STALL;
  logic [31:0] Instr_PC_IN_IF;
  logic [31:0] Instr_PC_IN_ID;
  logic        is_Branch_IN_ID;
  logic        is_Taken_IN_ID;
  logic [31:0] Alt_PC_IN_ID;
  logic        FLUSH;
  logic        take_Branch_OUT_IF;
  logic [31:0] take_Alt_PC_OUT_IF;
`ifdef BTB_STATS_EN
  logic [31:0] stat_hits_OUT;
  logic [31:0] stat_mispred_OUT;

  modport master (
    output STALL, Instr_PC_IN_IF, Instr_PC_IN_ID, is_Branch_IN_ID,
           is_Taken_IN_ID, Alt_PC_IN_ID,
    input  FLUSH, take_Branch_OUT_IF, take_Alt_PC_OUT_IF,
           stat_hits_OUT, stat_mispred_OUT
  );

  modport slave (
    input  STALL, Instr_PC_IN_IF, Instr_PC_IN_ID, is_Branch_IN_ID,
           is_Taken_IN_ID, Alt_PC_IN_ID,
    output FLUSH, take_Branch_OUT_IF, take_Alt_PC_OUT_IF,
           stat_hits_OUT, stat_mispred_OUT
  );
`else
  modport master (
    output STALL, Instr_PC_IN_IF, Instr_PC_IN_ID, is_Branch_IN_ID,
           is_Taken_IN_ID, Alt_PC_IN_ID,
    input  FLUSH, take_Branch_OUT_IF, take_Alt_PC_OUT_IF
  );

  modport slave (
    input  STALL, Instr_PC_IN_IF, Instr_PC_IN_ID, is_Branch_IN_ID,
           is_Taken_IN_ID, Alt_PC_IN_ID,
    output FLUSH, take_Branch_OUT_IF, take_Alt_PC_OUT_IF
  );
`endif
endinterface

// File: rtl/btb_assoc.sv
// -----------------------------------------------------------------------------
// btb_assoc -- set-associative branch target buffer with 2-bit counters.
//
// Lookup is combinational on the IF PC; the prediction is registered onto the
// outputs one cycle later and carried alongside the instruction into decode,
// where it is compared with the resolved branch. A mismatch pulses FLUSH and
// redirects fetch. Branches in decode train the table (counter, target, LRU).
//
// Ports
//   CLK    single clock, rising edge
//   RESET  asynchronous, active-high; clears valid bits, ages, counters (to 1),
//          carried prediction and output registers
//   bus    btb_assoc_if.slave (fetch/decode signals, registered outputs)
//
// Parameters: SETS (power of two), WAYS (1, 2 or 4), IDX_W, TAG_W.
// Optional macro: BTB_STATS_EN adds saturating hit / mispredict counters.
// -----------------------------------------------------------------------------
module btb_assoc #(
  parameter int SETS  = 512,
  parameter int WAYS  = 2,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input logic        CLK,
  input logic        RESET,
  btb_assoc_if.slave bus
);

  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int AGE_W = WAY_W;

  // Table storage: valid/counter/age are control (reset), tag/target are data.
  logic [WAYS-1:0]  valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [31:0]      tgt_q   [SETS][WAYS];
  logic [1:0]       ctr_q   [SETS][WAYS];
  logic [AGE_W-1:0] age_q   [SETS][WAYS];

  function automatic logic [1:0] ctr_sat(input logic [1:0] c, input logic up);
    if (up) return (c == 2'd3) ? c : c + 2'd1;
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  function automatic logic [31:0] cnt_sat(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: IF lookup and ID resolve (combinational on table contents)
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] if_idx, id_idx;
  logic [TAG_W-1:0] if_tag, id_tag;
  logic             if_hit, if_ctr_hi;
  logic [31:0]      if_tgt;
  logic             if_pred_tk;
  logic [31:0]      if_pred_pc;

  assign if_idx = bus.Instr_PC_IN_IF[IDX_W+1:2];
  assign if_tag = bus.Instr_PC_IN_IF[31:IDX_W+2];
  assign id_idx = bus.Instr_PC_IN_ID[IDX_W+1:2];
  assign id_tag = bus.Instr_PC_IN_ID[31:IDX_W+2];

  always_comb begin
    if_hit    = 1'b0;
    if_ctr_hi = 1'b0;
    if_tgt    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[if_idx][w] && (tag_q[if_idx][w] == if_tag)) begin
        if_hit    = 1'b1;
        if_ctr_hi = ctr_q[if_idx][w][1];
        if_tgt    = tgt_q[if_idx][w];
      end
    end
  end

  assign if_pred_tk = if_hit & if_ctr_hi;
  assign if_pred_pc = if_pred_tk ? if_tgt : bus.Instr_PC_IN_IF + 32'd4;

  logic             id_hit, inv_found;
  logic [WAY_W-1:0] id_way, inv_way, lru_way, upd_way;
  logic [AGE_W-1:0] best_age, upd_age;
  logic [1:0]       id_ctr;

  always_comb begin
    id_hit    = 1'b0;
    id_way    = '0;
    id_ctr    = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    best_age  = age_q[id_idx][0];
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[id_idx][w] && (tag_q[id_idx][w] == id_tag)) begin
        id_hit = 1'b1;
        id_way = WAY_W'(w);
        id_ctr = ctr_q[id_idx][w];
      end
    end
    // Descending scan so the lowest-numbered invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[id_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    // Oldest way; strict compare keeps the lowest index on ties.
    for (int w = 1; w < WAYS; w++) begin
      if (age_q[id_idx][w] > best_age) begin
        best_age = age_q[id_idx][w];
        lru_way  = WAY_W'(w);
      end
    end
  end

  logic br, tk, do_alloc, do_touch, mispred;
  logic [31:0] redirect_pc;

  // Carried prediction for the instruction now in decode.
  logic        pred_tk_p1;
  logic [31:0] pred_tgt_p1;

  assign br       = bus.is_Branch_IN_ID;
  assign tk       = bus.is_Taken_IN_ID;
  assign do_alloc = br & ~id_hit & tk;
  assign do_touch = br & (id_hit | tk);
  assign upd_way  = id_hit ? id_way : (inv_found ? inv_way : lru_way);
  assign upd_age  = age_q[id_idx][upd_way];

  assign mispred     = br & ((pred_tk_p1 != tk) ||
                             (pred_tk_p1 & tk & (pred_tgt_p1 != bus.Alt_PC_IN_ID)));
  assign redirect_pc = tk ? bus.Alt_PC_IN_ID : bus.Instr_PC_IN_ID + 32'd8;

  // ---------------------------------------------------------------------------
  // Stage p1: registered outputs, carried prediction, table update
  // ---------------------------------------------------------------------------
  logic        flush_p1, take_p1;
  logic [31:0] alt_pc_p1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      flush_p1   <= 1'b0;
      take_p1    <= 1'b0;
      alt_pc_p1  <= '0;
      pred_tk_p1 <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          ctr_q[s][w] <= 2'd1;
          age_q[s][w] <= '0;
        end
      end
    end else if (!bus.STALL) begin
      if (mispred) begin
        flush_p1   <= 1'b1;
        take_p1    <= 1'b1;
        alt_pc_p1  <= redirect_pc;
        pred_tk_p1 <= 1'b0;
      end else begin
        flush_p1   <= 1'b0;
        take_p1    <= if_pred_tk;
        alt_pc_p1  <= if_pred_pc;
        pred_tk_p1 <= if_pred_tk;
      end
      if (do_touch) begin
        if (do_alloc) begin
          valid_q[id_idx][upd_way] <= 1'b1;
          ctr_q[id_idx][upd_way]   <= 2'd2;
        end else begin
          ctr_q[id_idx][upd_way] <= ctr_sat(id_ctr, tk);
        end
        // Touched way becomes youngest; ways no older than it age by one.
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == upd_way)
            age_q[id_idx][w] <= '0;
          else if ((age_q[id_idx][w] <= upd_age) &&
                   (age_q[id_idx][w] != AGE_W'(WAYS - 1)))
            age_q[id_idx][w] <= age_q[id_idx][w] + AGE_W'(1);
        end
      end
    end
  end

  // Tag/target writes are invisible while the entry is invalid, so a reset
  // landing on an update cycle needs no special handling here.
  always_ff @(posedge CLK) begin
    if (!bus.STALL) begin
      pred_tgt_p1 <= if_pred_pc;
      if (br && tk) begin
        tag_q[id_idx][upd_way] <= id_tag;
        tgt_q[id_idx][upd_way] <= bus.Alt_PC_IN_ID;
      end
    end
  end

  assign bus.FLUSH              = flush_p1;
  assign bus.take_Branch_OUT_IF = take_p1;
  assign bus.take_Alt_PC_OUT_IF = alt_pc_p1;

`ifdef BTB_STATS_EN
  logic [31:0] hits_p1, misp_p1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hits_p1 <= '0;
      misp_p1 <= '0;
    end else if (!bus.STALL) begin
      if (if_hit)  hits_p1 <= cnt_sat(hits_p1);
      if (mispred) misp_p1 <= cnt_sat(misp_p1);
    end
  end

  assign bus.stat_hits_OUT    = hits_p1;
  assign bus.stat_mispred_OUT = misp_p1;
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// -----------------------------------------------------------------------------
// tb_btb_assoc -- directed scenarios plus randomized traffic for btb_assoc,
// checked every cycle against a behavioural BTB model (timestamp LRU).
// -----------------------------------------------------------------------------
module tb_btb_assoc;
  localparam int SETS  = 512;
  localparam int WAYS  = 2;
  localparam int IDX_W = 9;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  btb_assoc_if bus();

  btb_assoc #(.SETS(SETS), .WAYS(WAYS)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  bit          m_v   [SETS][WAYS];
  logic [31:0] m_tag [SETS][WAYS];
  logic [31:0] m_tgt [SETS][WAYS];
  int          m_ctr [SETS][WAYS];
  longint      m_last[SETS][WAYS];
  longint      m_now;
  bit          c_tk;
  logic [31:0] c_tgt;
  bit          e_flush, e_tb;
  logic [31:0] e_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_v[s][w]    = 1'b0;
        m_ctr[s][w]  = 1;
        m_last[s][w] = 0;
      end
    m_now   = 1;
    c_tk    = 1'b0;
    c_tgt   = '0;
    e_flush = 1'b0;
    e_tb    = 1'b0;
    e_pc    = '0;
  endtask

  task automatic model_step();
    logic [31:0] pif, pid, alt, ppc, tg;
    int s, hw, v;
    bit hit, ptk, br, tk, mis;
    pif = bus.Instr_PC_IN_IF;
    pid = bus.Instr_PC_IN_ID;
    alt = bus.Alt_PC_IN_ID;
    br  = bus.is_Branch_IN_ID;
    tk  = bus.is_Taken_IN_ID;
    // prediction from current (pre-update) table
    s   = int'((pif >> 2) % SETS);
    tg  = pif >> (IDX_W + 2);
    ptk = 1'b0;
    ppc = pif + 32'd4;
    for (int w = 0; w < WAYS; w++)
      if (m_v[s][w] && m_tag[s][w] == tg && m_ctr[s][w] >= 2) begin
        ptk = 1'b1;
        ppc = m_tgt[s][w];
      end
    mis = br && ((c_tk != tk) || (c_tk && tk && c_tgt != alt));
    if (mis) begin
      e_flush = 1'b1;
      e_tb    = 1'b1;
      e_pc    = tk ? alt : pid + 32'd8;
      c_tk    = 1'b0;
      c_tgt   = '0;
    end else begin
      e_flush = 1'b0;
      e_tb    = ptk;
      e_pc    = ppc;
      c_tk    = ptk;
      c_tgt   = ppc;
    end
    // training
    if (br) begin
      s  = int'((pid >> 2) % SETS);
      tg = pid >> (IDX_W + 2);
      hit = 1'b0;
      hw  = 0;
      for (int w = 0; w < WAYS; w++)
        if (m_v[s][w] && m_tag[s][w] == tg) begin
          hit = 1'b1;
          hw  = w;
        end
      if (hit) begin
        if (tk) begin
          if (m_ctr[s][hw] < 3) m_ctr[s][hw]++;
          m_tgt[s][hw] = alt;
        end else if (m_ctr[s][hw] > 0) begin
          m_ctr[s][hw]--;
        end
        m_last[s][hw] = m_now;
      end else if (tk) begin
        v = -1;
        for (int w = 0; w < WAYS; w++)
          if (!m_v[s][w] && v < 0) v = w;
        if (v < 0) begin
          v = 0;
          for (int w = 1; w < WAYS; w++)
            if (m_last[s][w] < m_last[s][v]) v = w;
        end
        m_v[s][v]    = 1'b1;
        m_tag[s][v]  = tg;
        m_tgt[s][v]  = alt;
        m_ctr[s][v]  = 2;
        m_last[s][v] = m_now;
      end
    end
    m_now++;
  endtask

  always @(posedge CLK or posedge RESET) begin
    if (RESET) model_reset();
    else if (!bus.STALL) model_step();
  end

  // Per-cycle comparison against the model
  always @(negedge CLK) begin
    if (chk_en) begin
      check("flush", {31'd0, bus.FLUSH}, {31'd0, e_flush});
      check("take_branch", {31'd0, bus.take_Branch_OUT_IF}, {31'd0, e_tb});
      check("alt_pc", bus.take_Alt_PC_OUT_IF, e_pc);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit st, input logic [31:0] pif, input logic [31:0] pid,
                       input bit br, input bit tk, input logic [31:0] alt);
    bus.STALL           = st;
    bus.Instr_PC_IN_IF  = pif;
    bus.Instr_PC_IN_ID  = pid;
    bus.is_Branch_IN_ID = br;
    bus.is_Taken_IN_ID  = tk;
    bus.Alt_PC_IN_ID    = alt;
  endtask

  // Pins both the DUT and the model to a hand-computed value.
  task automatic lit(input string name, input logic [31:0] req);
    logic [31:0] act, mdl;
    case (name)
      "flush": begin act = {31'd0, bus.FLUSH};              mdl = {31'd0, e_flush}; end
      "tb":    begin act = {31'd0, bus.take_Branch_OUT_IF}; mdl = {31'd0, e_tb};    end
      default: begin act = bus.take_Alt_PC_OUT_IF;          mdl = e_pc;            end
    endcase
    check({"lit_", name}, act, req);
    check({"model_", name}, mdl, req);
  endtask

  function automatic logic [31:0] rpc();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 32'hFFFF_FFFC;
    if (r == 1) return $urandom & 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 2)) << 2);
  endfunction

  logic [31:0] prev_pif, r_pif, r_pid;
  bit          r_st;

  initial begin
    RESET = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    lit("flush", 0); lit("tb", 0); lit("pc", 0);
    chk_en = 1'b1;
    RESET  = 1'b0;

    // cold fetch misses
    drive(0, 32'h1000, 0, 0, 0, 0); tick();
    lit("tb", 0); lit("pc", 32'h1004);

    // taken branch predicted not-taken -> redirect, allocate
    drive(0, 32'h1004, 32'h1000, 1, 1, 32'h2000); tick();
    lit("flush", 1); lit("tb", 1); lit("pc", 32'h2000);
    drive(0, 32'h1000, 32'h2000, 0, 0, 0); tick();
    lit("flush", 0); lit("tb", 1); lit("pc", 32'h2000);

    // predicted taken, resolved not-taken -> PC+8, counter 2->1
    drive(0, 32'h2000, 32'h1000, 1, 0, 0); tick();
    lit("flush", 1); lit("pc", 32'h1008);
    drive(0, 32'h1000, 0, 0, 0, 0); tick();
    lit("tb", 0); lit("pc", 32'h1004);

    // three taken branches in set 0: 0x1000 becomes LRU and is evicted
    drive(0, 32'h0044, 32'h1000, 1, 1, 32'h5000); tick();
    drive(0, 32'h0044, 32'h1800, 1, 1, 32'h5800); tick();
    drive(0, 32'h0044, 32'h2000, 1, 1, 32'h6000); tick();
    drive(0, 32'h1000, 0, 0, 0, 0); tick();
    lit("tb", 0); lit("pc", 32'h1004);
    drive(0, 32'h2000, 0, 0, 0, 0); tick();
    lit("tb", 1); lit("pc", 32'h6000);
    drive(0, 32'h1800, 0, 0, 0, 0); tick();
    lit("tb", 1); lit("pc", 32'h5800);

    // stall with a mispredicting branch in decode
    drive(1, 32'h1804, 32'h1800, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      lit("flush", 0); lit("tb", 1); lit("pc", 32'h5800);
    end
    bus.STALL = 1'b0;
    tick();
    lit("flush", 1); lit("tb", 1); lit("pc", 32'h1808);

    // reset asserted during an allocation cycle
    drive(0, 32'h0, 32'h3000, 1, 1, 32'h7000);
    #2;
    RESET = 1'b1;
    #1;
    lit("flush", 0); lit("tb", 0); lit("pc", 0);
    tick();
    RESET = 1'b0;
    drive(0, 32'h3000, 0, 0, 0, 0); tick();
    lit("tb", 0); lit("pc", 32'h3004);
    drive(0, 32'h1800, 0, 0, 0, 0); tick();
    lit("tb", 0); lit("pc", 32'h1804);

    // address wrap on PC+8 and PC+4
    drive(0, 32'h0, 32'hFFFF_FFF8, 1, 1, 32'h100); tick();
    lit("flush", 1); lit("pc", 32'h100);
    drive(0, 32'hFFFF_FFF8, 0, 0, 0, 0); tick();
    lit("tb", 1); lit("pc", 32'h100);
    drive(0, 32'h100, 32'hFFFF_FFF8, 1, 0, 0); tick();
    lit("flush", 1); lit("pc", 32'h0);
    drive(0, 32'hFFFF_FFFC, 0, 0, 0, 0); tick();
    lit("flush", 0); lit("tb", 0); lit("pc", 32'h0);

    // randomized traffic
    prev_pif = 32'hFFFF_FFFC;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
      end
      r_st  = ($urandom_range(0, 9) == 0);
      r_pif = rpc();
      r_pid = ($urandom_range(0, 4) != 0) ? prev_pif : rpc();
      drive(r_st, r_pif, r_pid, $urandom_range(0, 1) == 1, $urandom_range(0, 4) < 3,
            32'h4000 | (32'($urandom_range(0, 3)) << 4));
      if (!r_st) prev_pif = r_pif;
      tick();
    end

    bus.STALL = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
